aes_round_controller: RTL
=========================

# aes_round_controller

Iterative AES-128 encryption sequencer. Accepts one plaintext block per valid/ready handshake and performs the initial AddRoundKey. It then steps an external single-round datapath through rounds 1..NR, supplying the correct 128-bit slice of the expanded key each cycle, and presents the ciphertext on a valid/ready output. It sits between the key-expansion block, which supplies the expanded key, and the shared round datapath. The round datapath is not part of this block.

## Interface
- NR, 10, number of rounds; expanded-key width is 128*(NR+1)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  plaintext offered
- in_ready  out  1  controller can accept plaintext
- plaintext  in  128  input block
- expanded_key  in  128*(NR+1)  round key r is expanded_key[128*r +: 128]; key 0 is bits [127:0]
- round_in  out  128  current state register, to the round datapath
- round_key  out  128  key for the current round
- round_last  out  1  high on round NR; the datapath omits MixColumns
- round_out  in  128  combinational datapath result for (round_in, round_key, round_last)
- out_valid  out  1  ciphertext available
- out_ready  in  1  consumer accepts ciphertext
- out_data  out  128  ciphertext, equal to the state register
- busy  out  1  high in ROUND or DONE
- round_idx  out  4  current round counter

## Operation
- FSM states: IDLE, ROUND, DONE.
- IDLE
  - in_ready=1.
  - On in_valid: state_reg <= plaintext ^ expanded_key[127:0], round_idx <= 1, go to ROUND.
- ROUND
  - round_key = expanded_key[128*round_idx +: 128].
  - round_last = (round_idx==NR).
  - Each cycle: state_reg <= round_out.
  - If round_idx==NR: go to DONE and hold round_idx. Otherwise round_idx <= round_idx+1.
- DONE
  - out_valid=1. out_data stays stable until out_ready.
  - On out_ready without in_valid: go to IDLE.
  - in_ready = IDLE | (DONE & out_ready), a combinational path from out_ready.
  - Simultaneous out_ready and in_valid in DONE: the output handshake completes and the new block is loaded exactly as in IDLE. The FSM goes directly to ROUND, with no bubble cycle.
- Outside ROUND, round_key = expanded_key[127:0] and round_last=0.
- The controller does not latch expanded_key. It must stay stable from acceptance until the out_valid handshake completes; changes during that window give undefined ciphertext.
- in_valid while busy (and not in the DONE&out_ready case) is ignored and not acknowledged.
- out_valid does not depend combinationally on out_ready.

## Timing
- Reset values: FSM=IDLE, state_reg=0, round_idx=0, out_valid=0, busy=0, in_ready=1, round_last=0.
- rst has priority over all events. rst mid-ROUND or in DONE abandons the block: no out_valid, and the next cycle is IDLE.
- Latency: the acceptance edge is edge 0. Rounds 1..NR complete on edges 1..NR. out_valid is high from the cycle after edge NR, i.e. 10 cycles after acceptance for NR=10.
- Throughput: one block per NR+1 cycles with out_ready held high (back-to-back acceptance in DONE).
- round_idx width is 4 bits. NR must be at most 14. Elaboration fails otherwise.

## Structure
- Shared package aes_pkg holds:
  - AES_BLOCK_W=128
  - AES128_NR=10
  - the controller state enum {IDLE, ROUND, DONE}
  - the function for the round-key slice index
- One sub-module: aes_round_key_select, a pure mux from expanded_key and round_idx to round_key. It is reused by a future decrypt controller (reverse index).
- Top level holds the FSM, state_reg, round_idx and handshake logic.

## Test plan
- FIPS-197 C.1 vector, bench instantiates the existing round datapath.
  - Stimulus: key 000102030405060708090a0b0c0d0e0f expanded, plaintext 00112233445566778899aabbccddeeff.
  - Response: out_data 69c4e0d86a7b0430d8cdb78070b4c55a. out_valid exactly 10 cycles after acceptance.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_data and out_valid stable, in_ready=0, a presented in_valid is not accepted.
- Back-to-back: two blocks with out_ready=1 throughout -> second acceptance in the first block's DONE cycle. Second out_valid 11 cycles after the first. Both ciphertexts correct.
- Reset mid-operation: rst asserted when round_idx=5 -> next cycle IDLE, round_idx=0, state_reg=0, in_ready=1. No out_valid. A new block then yields the correct ciphertext.
- Key schedule and round_last check with a stub datapath (round_out = round_in ^ round_key), keys r = {16{8'(r)}}, plaintext 0.
  - round_key equals key r in round r.
  - round_last high only when round_idx=10.
  - out_data = XOR of keys 0..10 = 0b0b0b0b0b0b0b0b0b0b0b0b0b0b0b0b.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants, controller state encoding and round-key slice helper.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES128_NR   = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } aes_ctrl_state_e;

  // Encryption walks keys 0..NR; decryption walks them in reverse order.
  function automatic logic [3:0] aes_key_slice(input logic [3:0] round_idx,
                                               input logic       reverse,
                                               input logic [3:0] nr);
    return reverse ? (nr - round_idx) : round_idx;
  endfunction

endpackage

// File: rtl/aes_round_controller_if.sv
// Plaintext input stream and ciphertext output stream of the AES round controller.
interface aes_round_controller_if;

  // Both streams use valid/ready: a beat transfers on a rising clk edge where
  // valid and ready are both high; once valid rises, data holds until transfer.
  logic                          in_valid;
  logic                          in_ready;
  logic [aes_pkg::AES_BLOCK_W-1:0] plaintext;
  logic                          out_valid;
  logic                          out_ready;
  logic [aes_pkg::AES_BLOCK_W-1:0] out_data;

  modport master (
    output in_valid, plaintext, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, plaintext, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/aes_round_key_select.sv
// Pure mux picking one 128-bit round key out of the expanded key.
module aes_round_key_select
  import aes_pkg::*;
#(
  parameter int   NR      = AES128_NR,
  parameter logic REVERSE = 1'b0
) (
  input  logic [AES_BLOCK_W*(NR+1)-1:0] expanded_key_i,
  input  logic [3:0]                    round_idx_i,
  output logic [AES_BLOCK_W-1:0]        round_key_o
);

  localparam logic [3:0] NR_L = 4'(NR);

  logic [AES_BLOCK_W-1:0] keys [NR+1];
  logic [3:0]             slice;

  for (genvar r = 0; r <= NR; r++) begin : g_keys
    assign keys[r] = expanded_key_i[AES_BLOCK_W*r +: AES_BLOCK_W];
  end

  assign slice = aes_key_slice(round_idx_i, REVERSE, NR_L);

  always_comb begin
    round_key_o = keys[0];
    if (slice <= NR_L) round_key_o = keys[slice];
  end

endmodule

// File: rtl/aes_round_controller.sv
// Iterative AES encryption sequencer: initial AddRoundKey, then steps an external
// single-round datapath through rounds 1..NR and presents the ciphertext.
module aes_round_controller
  import aes_pkg::*;
#(
  parameter int NR = AES128_NR
) (
  input  logic                          clk,
  input  logic                          rst,
  aes_round_controller_if.slave         io,
  input  logic [AES_BLOCK_W*(NR+1)-1:0] expanded_key_i,
  output logic [AES_BLOCK_W-1:0]        round_in_o,
  output logic [AES_BLOCK_W-1:0]        round_key_o,
  output logic                          round_last_o,
  input  logic [AES_BLOCK_W-1:0]        round_out_i,
  output logic                          busy_o,
  output logic [3:0]                    round_idx_o,
  output aes_ctrl_state_e               state_o
);

  if (NR < 1 || NR > 14) begin : g_bad_nr
    $error("aes_round_controller: NR must be within 1..14");
  end

  localparam logic [3:0] NR_L = 4'(NR);

  aes_ctrl_state_e        state_q;
  logic [AES_BLOCK_W-1:0] state_reg_q;
  logic [3:0]             round_idx_q;
  logic                   out_valid_q;
  logic                   busy_q;
  logic                   round_last_q;

  logic [3:0]             key_idx;
  logic [AES_BLOCK_W-1:0] init_state;
  logic                   accept;

  // Outside ROUND the key mux is parked on key 0, which the load also uses.
  assign key_idx    = (state_q == ROUND) ? round_idx_q : 4'd0;
  assign init_state = io.plaintext ^ expanded_key_i[AES_BLOCK_W-1:0];

  aes_round_key_select #(
    .NR      (NR),
    .REVERSE (1'b0)
  ) u_key_sel (
    .expanded_key_i (expanded_key_i),
    .round_idx_i    (key_idx),
    .round_key_o    (round_key_o)
  );

  // Accepting in DONE alongside out_ready removes the bubble between blocks.
  assign io.in_ready = (state_q == IDLE) || ((state_q == DONE) && io.out_ready);
  assign accept      = io.in_valid && io.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      state_reg_q  <= '0;
      round_idx_q  <= '0;
      out_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      round_last_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q      <= ROUND;
            state_reg_q  <= init_state;
            round_idx_q  <= 4'd1;
            busy_q       <= 1'b1;
            round_last_q <= (NR_L == 4'd1);
          end
        end
        ROUND: begin
          state_reg_q <= round_out_i;
          if (round_idx_q == NR_L) begin
            state_q      <= DONE;
            out_valid_q  <= 1'b1;
            round_last_q <= 1'b0;
          end else begin
            round_idx_q  <= round_idx_q + 4'd1;
            round_last_q <= ((round_idx_q + 4'd1) == NR_L);
          end
        end
        DONE: begin
          if (io.out_ready) begin
            out_valid_q <= 1'b0;
            if (accept) begin
              state_q      <= ROUND;
              state_reg_q  <= init_state;
              round_idx_q  <= 4'd1;
              round_last_q <= (NR_L == 4'd1);
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign round_in_o   = state_reg_q;
  assign round_last_o = round_last_q;
  assign io.out_valid = out_valid_q;
  assign io.out_data  = state_reg_q;
  assign busy_o       = busy_q;
  assign round_idx_o  = round_idx_q;
  assign state_o      = state_q;

endmodule
